// File: rtl/vector_mask_packer_if.sv
// Compare-beat input channel and packed-mask output channel of vector_mask_packer.
// master = compare/writeback environment, slave = the packer.
interface vector_mask_packer_if #(
    parameter int unsigned VLEN = 512
);
    logic            cmp_valid;
    logic            cmp_ready;
    logic [VLEN-1:0] cmp_data;
    logic            mask_valid;
    logic            mask_ready;
    logic [VLEN-1:0] mask_data;

    modport master (
        output cmp_valid, cmp_data, mask_ready,
        input  cmp_ready, mask_valid, mask_data
    );

    modport slave (
        input  cmp_valid, cmp_data, mask_ready,
        output cmp_ready, mask_valid, mask_data
    );
endinterface

// File: rtl/vector_mask_packer.sv
// Packs per-element compare flags (element LSB) from 1..8 beats into a bit-per-element mask.
// Optional MASK_PACK_TAIL_UNDISTURBED_EN: accumulator seeded from old_mask so tail bits are preserved.
module vector_mask_packer #(
    parameter int unsigned VLEN = 512,
    parameter int unsigned VL_W = $clog2(VLEN) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        sew,
    input  logic [VL_W-1:0]   vl,
`ifdef MASK_PACK_TAIL_UNDISTURBED_EN
    input  logic [VLEN-1:0]   old_mask,
`endif
    vector_mask_packer_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              sew_err
);

    localparam int unsigned LANES  = VLEN / 8;
    localparam int unsigned OFF_W  = VL_W + 1;
    localparam int unsigned BEAT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_OUTPUT
    } state_e;

    state_e              state_q, state_d;
    logic [VLEN-1:0]     acc_q, acc_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [1:0]          sew_q, sew_d;
    logic [VL_W-1:0]     vl_q, vl_d;
    logic                cmp_ready_q, mask_valid_q, busy_q, done_q, sew_err_q;
    logic                done_d, sew_err_d;

    logic [VL_W-1:0]     elems_c;
    logic [OFF_W-1:0]    off_c;
    logic [LANES-1:0]    flags_c, wmask_c;
    logic [VLEN-1:0]     merged_c, init_c;
    logic                last_c;
    logic                unused_cmp_bits_c;

    assign unused_cmp_bits_c = ^bus.cmp_data;

`ifdef MASK_PACK_TAIL_UNDISTURBED_EN
    assign init_c = old_mask;
`else
    assign init_c = '0;
`endif

    // Extract lane flags for the latched SEW and place them at this beat's element offset
    always_comb begin
        flags_c = '0;
        wmask_c = '0;
        case (sew_q)
            2'b00:   elems_c = VL_W'(VLEN / 8);
            2'b01:   elems_c = VL_W'(VLEN / 16);
            default: elems_c = VL_W'(VLEN / 32);
        endcase
        case (sew_q)
            2'b00: for (int i = 0; i < LANES; i++)     flags_c[i] = bus.cmp_data[i*8];
            2'b01: for (int i = 0; i < LANES / 2; i++) flags_c[i] = bus.cmp_data[i*16];
            2'b10: for (int i = 0; i < LANES / 4; i++) flags_c[i] = bus.cmp_data[i*32];
            default: flags_c = '0;
        endcase
        off_c = OFF_W'(beat_q) * OFF_W'(elems_c);
        for (int i = 0; i < LANES; i++) begin
            wmask_c[i] = (OFF_W'(i) < OFF_W'(elems_c)) && ((off_c + OFF_W'(i)) < OFF_W'(vl_q));
        end
        merged_c = (acc_q & ~(VLEN'(wmask_c) << off_c)) | (VLEN'(flags_c & wmask_c) << off_c);
        last_c   = ((off_c + OFF_W'(elems_c)) >= OFF_W'(vl_q)) || (beat_q == BEAT_W'(7));
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        beat_d    = beat_q;
        sew_d     = sew_q;
        vl_d      = vl_q;
        done_d    = 1'b0;
        sew_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (sew == 2'b11) begin
                        sew_err_d = 1'b1;
                    end else begin
                        acc_d   = init_c;
                        beat_d  = '0;
                        sew_d   = sew;
                        vl_d    = vl;
                        state_d = (vl == '0) ? S_OUTPUT : S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (bus.cmp_valid && cmp_ready_q) begin
                    acc_d  = merged_c;
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_c) state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (bus.mask_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output flags are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            beat_q       <= '0;
            sew_q        <= '0;
            vl_q         <= '0;
            cmp_ready_q  <= 1'b0;
            mask_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sew_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            beat_q       <= beat_d;
            sew_q        <= sew_d;
            vl_q         <= vl_d;
            cmp_ready_q  <= (state_d == S_COLLECT);
            mask_valid_q <= (state_d == S_OUTPUT);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= done_d;
            sew_err_q    <= sew_err_d;
        end
    end

    assign bus.cmp_ready  = cmp_ready_q;
    assign bus.mask_valid = mask_valid_q;
    assign bus.mask_data  = acc_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign sew_err        = sew_err_q;

endmodule

// File: tb/tb_vector_mask_packer.sv
// Randomized and directed bench for vector_mask_packer against an element-index reference model.
module tb_vector_mask_packer;

    localparam int unsigned VLEN = 512;
    localparam int unsigned VL_W = $clog2(VLEN) + 1;
`ifdef MASK_PACK_TAIL_UNDISTURBED_EN
    localparam bit TU = 1'b1;
`else
    localparam bit TU = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [1:0]      sew_in;
    logic [VL_W-1:0] vl_in;
    logic [VLEN-1:0] old_mask_in;
    logic            busy, done, sew_err;

    int n_vec = 0;
    int n_err = 0;

    vector_mask_packer_if #(.VLEN(VLEN)) bus ();

    vector_mask_packer #(.VLEN(VLEN), .VL_W(VL_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .sew     (sew_in),
        .vl      (vl_in),
`ifdef MASK_PACK_TAIL_UNDISTURBED_EN
        .old_mask(old_mask_in),
`endif
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .sew_err (sew_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] d;
        for (int k = 0; k < VLEN / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // mode 0 random, 1 sew32 directed pattern, 2 alternating bytes, 3 all ones
    function automatic logic [VLEN-1:0] gen_beat(input int mode, input int b);
        logic [VLEN-1:0] d;
        d = '0;
        case (mode)
            1: begin
                for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'h1;
                if (b == 1) begin
                    d[0 +: 32]  = 32'hFFFF_FFFE;
                    d[96 +: 32] = 32'h0;
                end
            end
            2: for (int j = 0; j < VLEN / 8; j++) d[j*8 +: 8] = (j % 2 == 0) ? 8'h01 : 8'hFE;
            3: d = '1;
            default: d = rand_vec();
        endcase
        return d;
    endfunction

    task automatic run_instr(input logic [1:0] s, input int v, input int mode, input int hold,
                             input bit start_in_hold, output logic [VLEN-1:0] got,
                             output logic [VLEN-1:0] old);
        logic [VLEN-1:0] beats [8];
        logic [VLEN-1:0] exp;
        int sw, e, nb, stall;
        sw = 8 << s;
        e  = VLEN / sw;
        nb = (v + e - 1) / e;
        old = rand_vec();
        for (int b = 0; b < nb; b++) beats[b] = gen_beat(mode, b);
        exp = TU ? old : '0;
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < e; i++)
                if (b * e + i < v) exp[b*e + i] = beats[b][i*sw];

        start = 1'b1; sew_in = s; vl_in = VL_W'(v); old_mask_in = old;
        step();
        start = 1'b0; sew_in = 2'($urandom_range(0, 2)); vl_in = VL_W'($urandom); old_mask_in = rand_vec();
        if (v != 0) check("busy_after_start", VLEN'(busy), VLEN'(1'b1));

        for (int b = 0; b < nb; b++) begin
            stall = (mode == 2 && (b == 3 || b == 5)) ? 2 : (mode == 0 ? $urandom_range(0, 2) : 0);
            repeat (stall) begin
                bus.cmp_valid = 1'b0; bus.cmp_data = rand_vec();
                step();
            end
            check("cmp_ready_collect", VLEN'(bus.cmp_ready), VLEN'(1'b1));
            bus.cmp_valid = 1'b1; bus.cmp_data = beats[b];
            step();
        end
        bus.cmp_valid = 1'b0; bus.cmp_data = rand_vec();

        check("mask_valid_latency", VLEN'(bus.mask_valid), VLEN'(1'b1));
        check("cmp_ready_output", VLEN'(bus.cmp_ready), VLEN'(1'b0));
        check("mask_data", bus.mask_data, exp);
        got = bus.mask_data;

        repeat (hold) begin
            if (start_in_hold) begin start = 1'b1; sew_in = 2'b01; vl_in = VL_W'(5); end
            step();
            check("hold_valid", VLEN'(bus.mask_valid), VLEN'(1'b1));
            check("hold_data", bus.mask_data, got);
        end
        bus.mask_ready = 1'b1;
        start = start_in_hold; sew_in = 2'b01; vl_in = VL_W'(5);
        step();
        bus.mask_ready = 1'b0; start = 1'b0;
        check("done_pulse", VLEN'(done), VLEN'(1'b1));
        check("valid_after_hs", VLEN'(bus.mask_valid), VLEN'(1'b0));
        check("busy_after_hs", VLEN'(busy), VLEN'(1'b0));
        step();
        check("done_single", VLEN'(done), VLEN'(1'b0));
        check("busy_idle", VLEN'(busy), VLEN'(1'b0));
    endtask

    initial begin
        logic [VLEN-1:0] got, old, pat;
        reset_n = 1'b0; start = 1'b0; sew_in = '0; vl_in = '0; old_mask_in = '0;
        bus.cmp_valid = 1'b0; bus.cmp_data = '0; bus.mask_ready = 1'b0;
        step(); step();
        reset_n = 1'b1;
        check("rst_cmp_ready", VLEN'(bus.cmp_ready), '0);
        check("rst_mask_valid", VLEN'(bus.mask_valid), '0);
        check("rst_mask_data", bus.mask_data, '0);
        check("rst_busy", VLEN'(busy), '0);
        check("rst_done", VLEN'(done), '0);
        check("rst_sew_err", VLEN'(sew_err), '0);

        // sew=32, vl=20, two beats
        run_instr(2'b10, 20, 1, 0, 1'b0, got, old);
        check("t1_low20", VLEN'(got[19:0]), VLEN'(20'h6FFFF));
        check("t1_tail", got >> 20, TU ? (old >> 20) : '0);

        // sew=8, vl=VLEN, alternating flags with stalls on beats 3 and 5
        run_instr(2'b00, VLEN, 2, 0, 1'b0, got, old);
        pat = {256{2'b01}};
        check("t2_pattern", got, pat);

        // unsupported SEW
        start = 1'b1; sew_in = 2'b11; vl_in = VL_W'(16);
        step();
        start = 1'b0;
        check("sew_err_pulse", VLEN'(sew_err), VLEN'(1'b1));
        check("sew_err_busy", VLEN'(busy), '0);
        check("sew_err_ready", VLEN'(bus.cmp_ready), '0);
        step();
        check("sew_err_clear", VLEN'(sew_err), '0);
        check("sew_err_idle", VLEN'(busy), '0);

        // vl=0 goes straight to output
        run_instr(2'b01, 0, 0, 0, 1'b0, got, old);
        check("vl0_data", got, TU ? old : '0);

        // writeback back-pressure with a second start during the stall
        run_instr(2'b01, 40, 0, 5, 1'b1, got, old);

        // reset after the first beat of a two-beat instruction
        start = 1'b1; sew_in = 2'b10; vl_in = VL_W'(20); old_mask_in = '1;
        step();
        start = 1'b0;
        bus.cmp_valid = 1'b1; bus.cmp_data = gen_beat(3, 0);
        step();
        bus.cmp_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mid_rst_ready", VLEN'(bus.cmp_ready), '0);
        check("mid_rst_valid", VLEN'(bus.mask_valid), '0);
        check("mid_rst_data", bus.mask_data, '0);
        check("mid_rst_busy", VLEN'(busy), '0);
        check("mid_rst_done", VLEN'(done), '0);
        check("mid_rst_sew_err", VLEN'(sew_err), '0);
        run_instr(2'b10, 20, 0, 1, 1'b0, got, old);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] s;
            int e;
            s = 2'($urandom_range(0, 2));
            e = VLEN >> (3 + s);
            run_instr(s, $urandom_range(0, 8 * e), 0, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), got, old);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
